maluma_dispatcher: RTL and testbench

Command-side initiator for the mALUma IEEE-754 ALU. It accepts FP operation commands over a valid/ready interface and runs the ALU's required per-operation sequence: ALU reset pulse, setup cycle, start pulse, then wait for `valid_out`. It captures result and flags into a held response, and keeps sticky exception flags and an operation counter. It sits between the system command source and the mALUma instance.

---
 rtl/maluma_pkg.sv | 44 ++++
 rtl/maluma_timeout_ctr.sv | 35 +++
 rtl/maluma_dispatcher.sv | 182 ++++++++++++++++++
 tb/tb_maluma_dispatcher.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maluma_pkg.sv
// Shared definitions for the mALUma command-side blocks: op codes, flag
// positions, response status codes, canonical NaNs and the dispatcher states.
package maluma_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  // Bit positions within the 5-bit {inexact, invalid, divzero, overflow, underflow} vector
  localparam int FLAG_INEXACT   = 4;
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIVZERO   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  localparam logic [4:0] FLAGS_INVALID = 5'b00001 << FLAG_INVALID;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_TIMEOUT = 2'b01;
  localparam logic [1:0] STAT_ILLEGAL = 2'b10;

  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [15:0] HP_QNAN = 16'h7E00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARST,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Half-precision values live in [15:0]; the upper half is always driven to zero.
  function automatic logic [31:0] hp_mask(input logic mode_fp, input logic [31:0] v);
    return mode_fp ? v : {16'h0000, v[15:0]};
  endfunction

endpackage

// File: rtl/maluma_timeout_ctr.sv
// Loadable down-counter: load sets the count, en decrements until zero.
// expire_o is high while the count is zero.
module maluma_timeout_ctr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/maluma_dispatcher.sv
// Runs one mALUma operation per command: ALU reset, setup, start, wait, then holds
// the response until rsp_ready. ALU start at cycle 3 after the command handshake.
module maluma_dispatcher
  import maluma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_op_a,
  input  logic [31:0]      cmd_op_b,
  input  logic [2:0]       cmd_op_code,
  input  logic             cmd_mode_fp,
  input  logic             cmd_round_mode,
  output logic             alu_rst,
  output logic             alu_start,
  output logic [31:0]      alu_op_a,
  output logic [31:0]      alu_op_b,
  output logic [2:0]       alu_op_code,
  output logic             alu_mode_fp,
  output logic             alu_round_mode,
  input  logic [31:0]      alu_result,
  input  logic             alu_valid_out,
  input  logic [4:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [1:0]       rsp_status,
  output logic [4:0]       sticky_flags,
  input  logic             clear_sticky,
  output logic [CNT_W-1:0] op_count
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]         opc_q, opc_d;
  logic               mode_q, mode_d, rnd_q, rnd_d;
  logic [31:0]        res_q, res_d;
  logic [4:0]         flg_q, flg_d;
  logic [1:0]         stat_q, stat_d;
  logic [4:0]         sticky_q, sticky_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               tmo_load, tmo_en, tmo_expire;

  maluma_timeout_ctr #(.W(TW)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmo_load),
    .load_val_i (TMO_LOAD),
    .en_i       (tmo_en),
    .expire_o   (tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    opc_d     = opc_q;
    mode_d    = mode_q;
    rnd_d     = rnd_q;
    res_d     = res_q;
    flg_d     = flg_q;
    stat_d    = stat_q;
    sticky_d  = clear_sticky ? '0 : sticky_q;
    count_d   = count_q;
    cmd_ready = 1'b0;
    alu_rst   = 1'b0;
    alu_start = 1'b0;
    rsp_valid = 1'b0;
    tmo_load  = 1'b0;
    tmo_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // Illegal ops never touch the ALU-facing registers.
          if (is_legal_op(cmd_op_code)) begin
            op_a_d  = hp_mask(cmd_mode_fp, cmd_op_a);
            op_b_d  = hp_mask(cmd_mode_fp, cmd_op_b);
            opc_d   = cmd_op_code;
            mode_d  = cmd_mode_fp;
            rnd_d   = cmd_round_mode;
            state_d = ST_ARST;
          end else begin
            res_d   = '0;
            flg_d   = FLAGS_INVALID;
            stat_d  = STAT_ILLEGAL;
            state_d = ST_RESP;
          end
        end
      end
      ST_ARST: begin
        alu_rst = 1'b1;
        state_d = ST_SETUP;
      end
      ST_SETUP: state_d = ST_START;
      ST_START: begin
        alu_start = 1'b1;
        tmo_load  = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        if (alu_valid_out) begin
          res_d   = hp_mask(mode_q, alu_result);
          flg_d   = alu_flags;
          stat_d  = STAT_OK;
          state_d = ST_RESP;
        end else if (tmo_expire) begin
          res_d   = mode_q ? SP_QNAN : {16'h0000, HP_QNAN};
          flg_d   = FLAGS_INVALID;
          stat_d  = STAT_TIMEOUT;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          sticky_d = sticky_d | flg_q;
          count_d  = count_q + CNT_W'(1);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!rst) begin
      cmd_ready = 1'b0;
      alu_rst   = 1'b1;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      opc_q    <= '0;
      mode_q   <= 1'b0;
      rnd_q    <= 1'b0;
      res_q    <= '0;
      flg_q    <= '0;
      stat_q   <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      opc_q    <= opc_d;
      mode_q   <= mode_d;
      rnd_q    <= rnd_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
      stat_q   <= stat_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign alu_op_a       = op_a_q;
  assign alu_op_b       = op_b_q;
  assign alu_op_code    = opc_q;
  assign alu_mode_fp    = mode_q;
  assign alu_round_mode = rnd_q;
  assign rsp_result     = res_q;
  assign rsp_flags      = flg_q;
  assign rsp_status     = stat_q;
  assign sticky_flags   = sticky_q;
  assign op_count       = count_q;

endmodule

// File: tb/tb_maluma_dispatcher.sv
// Scoreboard bench for maluma_dispatcher: directed cases plus randomized commands
// against a spec-level response model and a behavioural ALU.
module tb_maluma_dispatcher;

  localparam int TO = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [31:0]   cmd_op_a = '0, cmd_op_b = '0;
  logic [2:0]    cmd_op_code = '0;
  logic          cmd_mode_fp = 1'b0, cmd_round_mode = 1'b0;
  logic          alu_rst, alu_start;
  logic [31:0]   alu_op_a, alu_op_b;
  logic [2:0]    alu_op_code;
  logic          alu_mode_fp, alu_round_mode;
  logic [31:0]   alu_result = '0;
  logic          alu_valid_out = 1'b0;
  logic [4:0]    alu_flags = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_result;
  logic [4:0]    rsp_flags;
  logic [1:0]    rsp_status;
  logic [4:0]    sticky_flags;
  logic          clear_sticky = 1'b0;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  maluma_dispatcher #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_a(cmd_op_a), .cmd_op_b(cmd_op_b), .cmd_op_code(cmd_op_code),
    .cmd_mode_fp(cmd_mode_fp), .cmd_round_mode(cmd_round_mode),
    .alu_rst(alu_rst), .alu_start(alu_start),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_status(rsp_status),
    .sticky_flags(sticky_flags), .clear_sticky(clear_sticky), .op_count(op_count)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    logic [1:0]  st;
    int          hs;
    int          lat;
    bit          legal;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        mode;
    logic        rnd;
    int          lat;
    logic [31:0] res;
    logic [4:0]  flg;
  } alu_t;

  exp_t    exp_q[$];
  alu_t    alu_q[$];
  exp_t    cur;
  alu_t    beh;
  bit      have_cur = 1'b0;
  int      vectors = 0, miscompares = 0;
  int      cyc = 0, rsp_done = 0, rdy_low_until = -1;
  int      rst_cnt = 0, rst_cyc = -1, start_cnt = 0, start_cyc = -1;
  bit      force_clear = 1'b0, rand_clear = 1'b0;
  logic [4:0]    m_sticky = '0;
  logic [CW-1:0] m_count = '0;
  int      hs, issued;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready    = (cyc < rdy_low_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
      clear_sticky = force_clear || (rand_clear && ($urandom_range(0, 7) == 0));
    end
  end

  // Behavioural ALU: answers each start after a programmed delay, or never.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && alu_start) begin
        chk("alu_beh_available", alu_q.size() > 0, 1);
        if (alu_q.size() > 0) begin
          beh = alu_q.pop_front();
          chk("alu_op_a", alu_op_a, beh.a);
          chk("alu_op_b", alu_op_b, beh.b);
          chk("alu_op_code", alu_op_code, beh.op);
          chk("alu_mode_fp", alu_mode_fp, beh.mode);
          chk("alu_round_mode", alu_round_mode, beh.rnd);
          if (beh.lat >= 0) begin
            repeat (beh.lat + 1) @(negedge clk);
            alu_result    = beh.res;
            alu_flags     = beh.flg;
            alu_valid_out = 1'b1;
            @(negedge clk);
            alu_valid_out = 1'b0;
            alu_result    = $urandom;
            alu_flags     = 5'($urandom);
          end
        end
      end
    end
  end

  // ALU pin activity seen since the most recent command handshake.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) begin
        rst_cnt = 0; start_cnt = 0; rst_cyc = -1; start_cyc = -1;
      end
      if (alu_rst)   begin rst_cnt++;   rst_cyc = cyc;   end
      if (alu_start) begin start_cnt++; start_cyc = cyc; end
    end
  end

  // Response monitor and sticky/count model.
  always @(negedge clk) begin
    if (!rst) begin
      m_sticky = '0;
      m_count  = '0;
      have_cur = 1'b0;
    end else begin
      chk("sticky_flags", sticky_flags, m_sticky);
      chk("op_count", op_count, m_count);
      if (rsp_valid) begin
        if (!have_cur) begin
          chk("rsp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            have_cur = 1'b1;
            chk("rsp_latency", cyc - cur.hs, cur.lat);
            chk("alu_rst_pulses", rst_cnt, 32'(cur.legal));
            chk("alu_start_pulses", start_cnt, 32'(cur.legal));
            if (cur.legal) begin
              chk("alu_rst_cycle", rst_cyc - cur.hs, 1);
              chk("alu_start_cycle", start_cyc - cur.hs, 3);
            end
          end
        end
        if (have_cur) begin
          chk("rsp_result", rsp_result, cur.res);
          chk("rsp_flags", rsp_flags, 32'(cur.flg));
          chk("rsp_status", rsp_status, 32'(cur.st));
          chk("cmd_ready_busy", cmd_ready, 0);
        end
      end else if (have_cur) begin
        chk("rsp_valid_held", rsp_valid, 1);
      end
      if (rsp_valid && rsp_ready && have_cur) begin
        m_sticky = (clear_sticky ? 5'd0 : m_sticky) | cur.flg;
        m_count  = m_count + 1'b1;
        have_cur = 1'b0;
        rsp_done++;
      end else if (clear_sticky) begin
        m_sticky = '0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic mode, input logic rnd, input int lat,
                       input logic [31:0] res, input logic [4:0] flg,
                       input bit expect_rsp, output int hs_o);
    exp_t e;
    alu_t m;
    int   n;
    bit   legal;
    legal = (op <= 3'd3);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op_a = a; cmd_op_b = b; cmd_op_code = op;
    cmd_mode_fp = mode; cmd_round_mode = rnd;
    n = 0;
    hs_o = -1;
    while (hs_o < 0 && n < 64) begin
      @(negedge clk);
      if (cmd_ready) hs_o = cyc;
      n++;
    end
    if (hs_o < 0) begin
      chk("cmd_accept_timeout", cmd_ready, 1);
    end else begin
      e.hs = hs_o;
      e.legal = legal;
      if (!legal) begin
        e.res = 32'h0; e.flg = 5'b01000; e.st = 2'b10; e.lat = 1;
      end else if (lat < 0) begin
        e.res = mode ? 32'h7FC00000 : 32'h00007E00; e.flg = 5'b01000; e.st = 2'b01; e.lat = 4 + TO;
      end else begin
        e.res = mode ? res : (res & 32'h0000FFFF); e.flg = flg; e.st = 2'b00; e.lat = 5 + lat;
      end
      if (expect_rsp) begin
        exp_q.push_back(e);
        issued++;
      end
      if (legal) begin
        m.a = mode ? a : (a & 32'h0000FFFF);
        m.b = mode ? b : (b & 32'h0000FFFF);
        m.op = op; m.mode = mode; m.rnd = rnd; m.lat = lat; m.res = res; m.flg = flg;
        alu_q.push_back(m);
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op_a = $urandom; cmd_op_b = $urandom;
    cmd_op_code = 3'($urandom); cmd_mode_fp = 1'($urandom); cmd_round_mode = 1'($urandom);
  endtask

  task automatic drain(input int target);
    int n;
    n = 0;
    while (rsp_done < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_responses", rsp_done, target);
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    force_clear = 1'b1;
    @(negedge clk);
    force_clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int r, op, lat;
    issued = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 0);
    chk("reset_alu_rst", alu_rst, 1);
    chk("reset_alu_start", alu_start, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_status", rsp_status, 0);
    chk("reset_alu_op_a", alu_op_a, 0);
    chk("reset_op_count", op_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    issue(32'h40000000, 32'h40400000, 3'b000, 1'b1, 1'b0, 2, 32'h40A00000, 5'b00000, 1'b1, hs);
    drain(issued);
    chk("op_count_first", op_count, 1);
    issue(32'hFFFF4600, 32'hABCD4000, 3'b011, 1'b0, 1'b1, 3, 32'hDEAD4200, 5'b00000, 1'b1, hs);
    issue(32'h12345678, 32'h9ABCDEF0, 3'b110, 1'b1, 1'b0, 0, 32'h0, 5'b0, 1'b1, hs);
    issue(32'h3F800000, 32'h3F800000, 3'b010, 1'b1, 1'b0, -1, 32'h0, 5'b0, 1'b1, hs);
    issue(32'h00003C00, 32'h00003C00, 3'b001, 1'b0, 1'b0, -1, 32'h0, 5'b0, 1'b1, hs);
    issue(32'h3F800000, 32'h40000000, 3'b000, 1'b1, 1'b0, TO - 1, 32'h40400000, 5'b10000, 1'b1, hs);
    drain(issued);

    pulse_clear();
    chk("sticky_cleared_a", sticky_flags, 0);
    rdy_low_until = cyc + 14;
    issue(32'h40A00000, 32'h00000000, 3'b011, 1'b1, 1'b0, 0, 32'h7F800000, 5'b00100, 1'b1, hs);
    drain(issued);
    issue(32'h7F800000, 32'h7F800000, 3'b001, 1'b1, 1'b0, 1, 32'h7FC00000, 5'b01000, 1'b1, hs);
    drain(issued);
    chk("sticky_combined", sticky_flags, 5'b01100);
    pulse_clear();
    chk("sticky_cleared_b", sticky_flags, 0);

    // Reset while the ALU operation is outstanding: no response must appear.
    issue(32'h3F800000, 32'h3F800000, 3'b000, 1'b1, 1'b0, -1, 32'h0, 5'b0, 1'b0, hs);
    while (cyc < hs + 6) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_alu_rst", alu_rst, 1);
    chk("midreset_cmd_ready", cmd_ready, 0);
    chk("midreset_op_count", op_count, 0);
    chk("midreset_sticky", sticky_flags, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    rsp_done = 0;
    issued = 0;
    issue(32'h40000000, 32'h40000000, 3'b010, 1'b1, 1'b0, 0, 32'h40800000, 5'b00000, 1'b1, hs);
    drain(issued);
    chk("op_count_after_reset", op_count, 1);

    rand_clear = 1'b1;
    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 11);
      op  = (r < 8) ? (r % 4) : (r - 4);
      r   = $urandom_range(0, 9);
      lat = (r >= 8) ? -1 : r;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue($urandom, $urandom, 3'(op), 1'($urandom), 1'($urandom), lat,
            $urandom, 5'($urandom), 1'b1, hs);
    end
    drain(issued);
    rand_clear = 1'b0;
    chk("alu_queue_empty", alu_q.size(), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
